// File: rtl/mipi_clk_lane_tx_ctrl.sv
// mipi_clk_lane_tx_ctrl
// D-PHY clock-lane TX sequencer running on the byte clock. It walks the
// LP-TX / HS-TX pins through the HS entry and exit sequences and raises
// HS_READY while the HS clock is toggling and valid for the data lanes.
// Optional ultra-low-power state support is compiled in with the
// MIPI_CLK_ULPS_EN macro.
module mipi_clk_lane_tx_ctrl #(
  parameter int unsigned T_LPX     = 4,
  parameter int unsigned T_PREPARE = 3,
  parameter int unsigned T_ZERO    = 16,
  parameter int unsigned T_PRE     = 2,
  parameter int unsigned T_POST    = 8,
  parameter int unsigned T_TRAIL   = 4,
  parameter int unsigned T_HSEXIT  = 6,
  parameter int unsigned T_WAKEUP  = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       BYTECLK,
  input  logic       RST,
  input  logic       HS_REQ,
`ifdef MIPI_CLK_ULPS_EN
  input  logic       ULPS_REQ,
  output logic       ULPS_ACTIVE,
`endif
  output logic       HS_READY,
  output logic       BUSY,
  output logic [3:0] STATE,
  output logic       TXLPEN,
  output logic       DTXLPP,
  output logic       DTXLPN,
  output logic       TXHSEN,
  output logic       TXHSPD,
  output logic       TXHSGATE
);

  typedef enum logic [3:0] {
    ST_STOP      = 4'h0,
    ST_HS_RQST   = 4'h1,
    ST_PREPARE   = 4'h2,
    ST_ZERO      = 4'h3,
    ST_PRE       = 4'h4,
    ST_RUN       = 4'h5,
    ST_POST      = 4'h6,
    ST_TRAIL     = 4'h7,
    ST_EXIT      = 4'h8
`ifdef MIPI_CLK_ULPS_EN
    ,
    ST_ULPS_RQST = 4'h9,
    ST_ULPS      = 4'hA,
    ST_ULPS_EXIT = 4'hB
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;

  // Every timing parameter has to fit the timer.
  if (T_LPX >= 2**CNT_W || T_PREPARE >= 2**CNT_W || T_ZERO >= 2**CNT_W ||
      T_PRE >= 2**CNT_W || T_POST >= 2**CNT_W || T_TRAIL >= 2**CNT_W ||
      T_HSEXIT >= 2**CNT_W || T_WAKEUP >= 2**CNT_W) begin : g_cfg_check
    $error("mipi_clk_lane_tx_ctrl: every T_* must be < 2**CNT_W");
  end

  // A duration of 0 is treated as 1 cycle.
  function automatic logic [CNT_W-1:0] cycles_to_load(input int unsigned t);
    return (t == 0) ? '0 : CNT_W'(t - 1);
  endfunction

  // Timer preload for a state being entered; untimed states load 0.
  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      ST_HS_RQST:   load_for = cycles_to_load(T_LPX);
      ST_PREPARE:   load_for = cycles_to_load(T_PREPARE);
      ST_ZERO:      load_for = cycles_to_load(T_ZERO);
      ST_PRE:       load_for = cycles_to_load(T_PRE);
      ST_POST:      load_for = cycles_to_load(T_POST);
      ST_TRAIL:     load_for = cycles_to_load(T_TRAIL);
      ST_EXIT:      load_for = cycles_to_load(T_HSEXIT);
`ifdef MIPI_CLK_ULPS_EN
      ST_ULPS_RQST: load_for = cycles_to_load(T_LPX);
      ST_ULPS_EXIT: load_for = cycles_to_load(T_WAKEUP);
`endif
      default:      load_for = '0;
    endcase
  endfunction

  // Pin pattern {TXLPEN, DTXLPP, DTXLPN, TXHSEN, TXHSPD, TXHSGATE} per state.
  function automatic logic [5:0] pins_for(input state_t s);
    case (s)
      ST_HS_RQST:             pins_for = 6'b101011;
      ST_PREPARE:             pins_for = 6'b100001;
      ST_ZERO, ST_TRAIL:      pins_for = 6'b000101;
      ST_PRE, ST_RUN, ST_POST: pins_for = 6'b000100;
`ifdef MIPI_CLK_ULPS_EN
      ST_ULPS_RQST,
      ST_ULPS_EXIT:           pins_for = 6'b110011;
      ST_ULPS:                pins_for = 6'b100011;
`endif
      default:                pins_for = 6'b111011;
    endcase
  endfunction

  // Next state and timer; a timed state advances on the edge where its timer is 0.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (HS_REQ) state_nxt = ST_HS_RQST;
`ifdef MIPI_CLK_ULPS_EN
        else if (ULPS_REQ) state_nxt = ST_ULPS_RQST;
`endif
      end
      ST_HS_RQST:   if (timer == '0) state_nxt = ST_PREPARE;
      ST_PREPARE:   if (timer == '0) state_nxt = ST_ZERO;
      ST_ZERO:      if (timer == '0) state_nxt = ST_PRE;
      ST_PRE:       if (timer == '0) state_nxt = ST_RUN;
      ST_RUN:       if (!HS_REQ) state_nxt = ST_POST;
      ST_POST:      if (timer == '0) state_nxt = ST_TRAIL;
      ST_TRAIL:     if (timer == '0) state_nxt = ST_EXIT;
      ST_EXIT:      if (timer == '0) state_nxt = ST_STOP;
`ifdef MIPI_CLK_ULPS_EN
      ST_ULPS_RQST: if (timer == '0) state_nxt = ST_ULPS;
      ST_ULPS:      if (!ULPS_REQ) state_nxt = ST_ULPS_EXIT;
      ST_ULPS_EXIT: if (timer == '0) state_nxt = ST_STOP;
`endif
      default:      state_nxt = ST_STOP;
    endcase

    if (state_nxt != state) timer_nxt = load_for(state_nxt);
    else if (timer != '0)   timer_nxt = timer - 1'b1;
    else                    timer_nxt = '0;
  end

  // State, timer and outputs registered together; outputs decode the next state.
  always_ff @(posedge BYTECLK) begin
    if (RST) begin
      state       <= ST_STOP;
      timer       <= '0;
      {TXLPEN, DTXLPP, DTXLPN, TXHSEN, TXHSPD, TXHSGATE} <= 6'b111011;
      HS_READY    <= 1'b0;
      BUSY        <= 1'b0;
`ifdef MIPI_CLK_ULPS_EN
      ULPS_ACTIVE <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      {TXLPEN, DTXLPP, DTXLPN, TXHSEN, TXHSPD, TXHSGATE} <= pins_for(state_nxt);
      HS_READY    <= (state_nxt == ST_RUN);
      BUSY        <= (state_nxt != ST_STOP);
`ifdef MIPI_CLK_ULPS_EN
      ULPS_ACTIVE <= (state_nxt == ST_ULPS);
`endif
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_mipi_clk_lane_tx_ctrl.sv
// tb_mipi_clk_lane_tx_ctrl
// Scoreboard bench for the clock-lane TX sequencer. Each stimulus edge pushes
// the expected post-edge outputs from a cycle-counting reference model; the
// scenario tasks pop and compare after the edge, plus absolute-edge checks.
module tb_mipi_clk_lane_tx_ctrl;

  localparam int unsigned T_LPX     = 4;
  localparam int unsigned T_PREPARE = 3;
  localparam int unsigned T_ZERO    = 16;
  localparam int unsigned T_PRE     = 2;
  localparam int unsigned T_POST    = 8;
  localparam int unsigned T_TRAIL   = 4;
  localparam int unsigned T_HSEXIT  = 6;
  localparam int unsigned T_WAKEUP  = 32;
`ifdef MIPI_CLK_ULPS_EN
  localparam bit ULPS_EN = 1'b1;
`else
  localparam bit ULPS_EN = 1'b0;
`endif
  localparam logic [11:0] STOP_VEC = {4'h0, 6'b111011, 1'b0, 1'b0};

  logic       BYTECLK = 1'b0;
  logic       RST     = 1'b1;
  logic       HS_REQ  = 1'b0;
  logic       HS_READY, BUSY;
  logic [3:0] STATE;
  logic       TXLPEN, DTXLPP, DTXLPN, TXHSEN, TXHSPD, TXHSGATE;
`ifdef MIPI_CLK_ULPS_EN
  logic       ULPS_REQ = 1'b0;
  logic       ULPS_ACTIVE;
`endif

  always #5 BYTECLK = ~BYTECLK;

  mipi_clk_lane_tx_ctrl #(
    .T_LPX(T_LPX), .T_PREPARE(T_PREPARE), .T_ZERO(T_ZERO), .T_PRE(T_PRE),
    .T_POST(T_POST), .T_TRAIL(T_TRAIL), .T_HSEXIT(T_HSEXIT),
    .T_WAKEUP(T_WAKEUP), .CNT_W(8)
  ) dut (
    .BYTECLK(BYTECLK), .RST(RST), .HS_REQ(HS_REQ),
`ifdef MIPI_CLK_ULPS_EN
    .ULPS_REQ(ULPS_REQ), .ULPS_ACTIVE(ULPS_ACTIVE),
`endif
    .HS_READY(HS_READY), .BUSY(BUSY), .STATE(STATE),
    .TXLPEN(TXLPEN), .DTXLPP(DTXLPP), .DTXLPN(DTXLPN),
    .TXHSEN(TXHSEN), .TXHSPD(TXHSPD), .TXHSGATE(TXHSGATE)
  );

  logic [11:0] obs;
  assign obs = {STATE, TXLPEN, DTXLPP, DTXLPN, TXHSEN, TXHSPD, TXHSGATE, HS_READY, BUSY};

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned edge_n  = 0;
  logic [11:0] sb[$];
  logic [11:0] exp_v;

  // Reference model: state number plus cycles already spent in a timed state.
  logic [3:0]  m_st  = 4'h0;
  int unsigned m_cnt = 0;

  function automatic int unsigned dur(input logic [3:0] s);
    case (s)
      4'h1: dur = T_LPX;
      4'h2: dur = T_PREPARE;
      4'h3: dur = T_ZERO;
      4'h4: dur = T_PRE;
      4'h6: dur = T_POST;
      4'h7: dur = T_TRAIL;
      4'h8: dur = T_HSEXIT;
      4'h9: dur = T_LPX;
      4'hB: dur = T_WAKEUP;
      default: dur = 1;
    endcase
    if (dur == 0) dur = 1;
  endfunction

  function automatic logic [3:0] after(input logic [3:0] s);
    case (s)
      4'h8, 4'hB: after = 4'h0;
      4'h9:       after = 4'hA;
      default:    after = s + 4'h1;
    endcase
  endfunction

  function automatic logic [11:0] exp_vec(input logic [3:0] s);
    logic [5:0] p;
    case (s)
      4'h1:             p = 6'b101011;
      4'h2:             p = 6'b100001;
      4'h3, 4'h7:       p = 6'b000101;
      4'h4, 4'h5, 4'h6: p = 6'b000100;
      4'h9, 4'hB:       p = 6'b110011;
      4'hA:             p = 6'b100011;
      default:          p = 6'b111011;
    endcase
    return {s, p, (s == 4'h5), (s != 4'h0)};
  endfunction

  task automatic model_step(input logic rst, input logic hs, input logic ulps);
    if (rst) begin
      m_st  = 4'h0;
      m_cnt = 0;
    end else begin
      case (m_st)
        4'h0: if (hs) m_st = 4'h1;
              else if (ULPS_EN && ulps) m_st = 4'h9;
        4'h5: if (!hs) m_st = 4'h6;
        4'hA: if (!ulps) m_st = 4'hB;
        default: begin
          m_cnt++;
          if (m_cnt >= dur(m_st)) begin
            m_st  = after(m_st);
            m_cnt = 0;
          end
        end
      endcase
    end
  endtask

  // Drive one edge of stimulus and queue the outputs expected after it.
  task automatic drive_edge(input logic rst, input logic hs, input logic ulps);
    RST    = rst;
    HS_REQ = hs;
`ifdef MIPI_CLK_ULPS_EN
    ULPS_REQ = ulps;
`endif
    model_step(rst, hs, ulps);
    sb.push_back(exp_vec(m_st));
    @(posedge BYTECLK);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 9; i++) begin
      drive_edge(i < 3, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL reset edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (obs !== STOP_VEC) $display("FAIL reset_idle: got %h want %h", obs, STOP_VEC);
    else n_pass++;
  endtask

  task automatic test_entry();
    int unsigned ev_e[5] = '{10, 14, 17, 33, 35};
    logic [3:0]  ev_s[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    for (int i = 0; i < 90; i++) begin
      drive_edge(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL entry edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
      n_total++;
      if ((TXHSEN & TXLPEN) !== 1'b0) $display("FAIL entry_hs_lp_excl edge %0d: got 1 want 0", edge_n);
      else n_pass++;
      for (int j = 0; j < 5; j++) begin
        if (edge_n == ev_e[j]) begin
          n_total++;
          if (STATE !== ev_s[j]) $display("FAIL entry_time edge %0d: got %h want %h", edge_n, STATE, ev_s[j]);
          else n_pass++;
        end
      end
      if (edge_n == 34 || edge_n == 35) begin
        n_total++;
        if (HS_READY !== (edge_n == 35)) $display("FAIL entry_ready edge %0d: got %b want %b", edge_n, HS_READY, edge_n == 35);
        else n_pass++;
      end
    end
  endtask

  task automatic test_exit();
    int unsigned ev_e[4] = '{100, 108, 112, 118};
    logic [3:0]  ev_s[4] = '{4'h6, 4'h7, 4'h8, 4'h0};
    for (int i = 0; i < 22; i++) begin
      drive_edge(1'b0, (i >= 1 && i <= 17), 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL exit edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
      n_total++;
      if ((TXHSEN & TXLPEN) !== 1'b0) $display("FAIL exit_hs_lp_excl edge %0d: got 1 want 0", edge_n);
      else n_pass++;
      for (int j = 0; j < 4; j++) begin
        if (edge_n == ev_e[j]) begin
          n_total++;
          if (STATE !== ev_s[j]) $display("FAIL exit_time edge %0d: got %h want %h", edge_n, STATE, ev_s[j]);
          else n_pass++;
        end
      end
      if (edge_n == 111 || edge_n == 112) begin
        n_total++;
        if (TXLPEN !== (edge_n == 112)) $display("FAIL exit_lpen edge %0d: got %b want %b", edge_n, TXLPEN, edge_n == 112);
        else n_pass++;
      end
      if (edge_n == 117 || edge_n == 118) begin
        n_total++;
        if (BUSY !== (edge_n == 117)) $display("FAIL exit_busy edge %0d: got %b want %b", edge_n, BUSY, edge_n == 117);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pulse();
    int unsigned k = edge_n + 1;
    int unsigned run_cycles = 0;
    for (int i = 0; i < 49; i++) begin
      drive_edge(1'b0, (i == 0), 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL pulse edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
      if (STATE == 4'h5) run_cycles++;
      if (edge_n == k + 25 || edge_n == k + 26 || edge_n == k + 44) begin
        n_total++;
        if (STATE !== ((edge_n == k + 25) ? 4'h5 : (edge_n == k + 26) ? 4'h6 : 4'h0))
          $display("FAIL pulse_time edge %0d: got %h", edge_n, STATE);
        else n_pass++;
      end
    end
    n_total++;
    if (run_cycles !== 1) $display("FAIL pulse_run_len: got %0d want 1", run_cycles);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 10; i++) begin
      drive_edge(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL rst_zero_seq edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (STATE !== 4'h3) $display("FAIL rst_in_zero_pre: got %h want 3", STATE);
    else n_pass++;
    drive_edge(1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    n_total++;
    if (obs !== STOP_VEC || exp_v !== STOP_VEC) $display("FAIL rst_in_zero: got %h want %h", obs, STOP_VEC);
    else n_pass++;
    for (int i = 0; i < 28; i++) begin
      drive_edge(1'b0, (i >= 2), 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL rst_run_seq edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (STATE !== 4'h5 || HS_READY !== 1'b1) $display("FAIL rst_in_run_pre: got %h/%b want 5/1", STATE, HS_READY);
    else n_pass++;
    drive_edge(1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    n_total++;
    if (obs !== STOP_VEC || exp_v !== STOP_VEC) $display("FAIL rst_in_run: got %h want %h", obs, STOP_VEC);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL rst_after edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
    end
  endtask

`ifdef MIPI_CLK_ULPS_EN
  task automatic test_ulps();
    int unsigned n_rqst = 0;
    int unsigned n_wake = 0;
    logic hs;
    logic ul;
    for (int i = 0; i < 45; i++) begin
      ul = (i < 10);
      hs = (i >= 4 && i < 30);
      drive_edge(1'b0, hs, ul);
      exp_v = sb.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL ulps edge %0d: got %h want %h", edge_n, obs, exp_v);
      else n_pass++;
      n_total++;
      if (ULPS_ACTIVE !== (m_st == 4'hA)) $display("FAIL ulps_active edge %0d: got %b want %b", edge_n, ULPS_ACTIVE, m_st == 4'hA);
      else n_pass++;
      if (STATE == 4'h9) n_rqst++;
      if (STATE == 4'hB) n_wake++;
    end
    n_total++;
    if (n_rqst !== T_LPX) $display("FAIL ulps_rqst_len: got %0d want %0d", n_rqst, T_LPX);
    else n_pass++;
    n_total++;
    if (n_wake !== T_WAKEUP) $display("FAIL ulps_wake_len: got %0d want %0d", n_wake, T_WAKEUP);
    else n_pass++;
    drive_edge(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    n_total++;
    if (STATE !== 4'h1 || obs !== exp_v) $display("FAIL ulps_hs_wins: got %h want %h", obs, exp_v);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_pulse();
    test_rst_mid();
`ifdef MIPI_CLK_ULPS_EN
    test_ulps();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
